// File: rtl/relu_maxpool_stream_if.sv
// Stream bundle between the conv layer, the pool/ReLU stage and its consumer.
// The slave side is the pooling block; the master side feeds it rows and drains pooled segments.
interface relu_maxpool_stream_if #(
   parameter int DATA_WIDTH = 16,
   parameter int SEG        = 14
);
   logic                            in_valid;
   logic                            in_ready;
   logic [SEG*DATA_WIDTH-1:0]       in_data;
   logic                            out_valid;
   logic                            out_ready;
   logic [(SEG/2)*DATA_WIDTH-1:0]   out_data;
   logic                            out_last;
   logic                            frame_done;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_last, frame_done
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_last, frame_done
   );
endinterface

// File: rtl/relu_maxpool_stream.sv
// 2x2 stride-2 max-pool followed by ReLU over a segmented row stream.
// Even rows are parked in a one-row line buffer; each odd-row segment is
// combined with the matching buffered segment into one pooled output segment.
//
//   state | meaning
//   FILL  | even row: store incoming segments into the line buffer
//   POOL  | odd row: wait for a segment, pool it against the buffer
//   OUT   | pooled segment presented, input stalled until it is taken
module relu_maxpool_stream #(
   parameter int DATA_WIDTH = 16,
   parameter int W          = 28,
   parameter int H          = 28,
   parameter int SEG        = 14
) (
   input  logic                  clk,
   input  logic                  reset,
   relu_maxpool_stream_if.slave  bus
);
   localparam int NSEG  = W / SEG;
   localparam int HALF  = SEG / 2;
   localparam int ROW_W = $clog2(H);
   localparam int SEG_W = $clog2(NSEG) + 1;
   localparam int IN_W  = SEG * DATA_WIDTH;
   localparam int OUT_W = HALF * DATA_WIDTH;

   typedef enum logic [1:0] {ST_FILL, ST_POOL, ST_OUT} state_t;

   state_t             state_q, state_d;
   logic [ROW_W-1:0]   row_q, row_d;
   logic [SEG_W-1:0]   seg_q, seg_d;
   logic [OUT_W-1:0]   out_data_q, out_data_d;
   logic               out_last_q, out_last_d;
   logic               frame_done_q, frame_done_d;
   logic [W*DATA_WIDTH-1:0] lb_q;
   logic [IN_W-1:0]    lb_seg;
   logic [OUT_W-1:0]   pooled;
   logic               seg_last;
   logic               row_last;

   assign seg_last = (seg_q == SEG_W'(NSEG - 1));
   assign row_last = (row_q == ROW_W'(H - 1));

   function automatic logic [DATA_WIDTH-1:0] relu_max4(
      input logic signed [DATA_WIDTH-1:0] a,
      input logic signed [DATA_WIDTH-1:0] b,
      input logic signed [DATA_WIDTH-1:0] c,
      input logic signed [DATA_WIDTH-1:0] d
   );
      logic signed [DATA_WIDTH-1:0] m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return (m < 0) ? '0 : m;
   endfunction

   // Line buffer: no reset, every segment is rewritten in FILL before POOL reads it.
   always_ff @(posedge clk) begin
      if (state_q == ST_FILL && bus.in_valid) begin
         for (int s = 0; s < NSEG; s++) begin
            if (seg_q == SEG_W'(s)) lb_q[s*IN_W +: IN_W] <= bus.in_data;
         end
      end
   end

   // Select the buffered even-row segment lined up with the current odd-row segment.
   always_comb begin
      lb_seg = '0;
      for (int s = 0; s < NSEG; s++) begin
         if (seg_q == SEG_W'(s)) lb_seg = lb_q[s*IN_W +: IN_W];
      end
   end

   // Pool each 2x2 window (two buffered pixels, two incoming pixels) and clamp negatives.
   always_comb begin
      pooled = '0;
      for (int j = 0; j < HALF; j++) begin
         pooled[j*DATA_WIDTH +: DATA_WIDTH] = relu_max4(
            lb_seg[(2*j)*DATA_WIDTH +: DATA_WIDTH],
            lb_seg[(2*j+1)*DATA_WIDTH +: DATA_WIDTH],
            bus.in_data[(2*j)*DATA_WIDTH +: DATA_WIDTH],
            bus.in_data[(2*j+1)*DATA_WIDTH +: DATA_WIDTH]);
      end
   end

   // State, position counters and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_FILL;
         row_q        <= '0;
         seg_q        <= '0;
         out_data_q   <= '0;
         out_last_q   <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         row_q        <= row_d;
         seg_q        <= seg_d;
         out_data_q   <= out_data_d;
         out_last_q   <= out_last_d;
         frame_done_q <= frame_done_d;
      end
   end

   // Next state: advance position on input accepts (FILL) and output handshakes (OUT).
   always_comb begin
      state_d      = state_q;
      row_d        = row_q;
      seg_d        = seg_q;
      out_data_d   = out_data_q;
      out_last_d   = out_last_q;
      frame_done_d = 1'b0;
      case (state_q)
         ST_FILL: begin
            if (bus.in_valid) begin
               if (seg_last) begin
                  seg_d   = '0;
                  row_d   = row_q + ROW_W'(1);
                  state_d = ST_POOL;
               end else begin
                  seg_d = seg_q + SEG_W'(1);
               end
            end
         end
         ST_POOL: begin
            if (bus.in_valid) begin
               out_data_d = pooled;
               out_last_d = row_last && seg_last;
               state_d    = ST_OUT;
            end
         end
         ST_OUT: begin
            if (bus.out_ready) begin
               if (seg_last) begin
                  seg_d   = '0;
                  state_d = ST_FILL;
                  if (row_last) begin
                     row_d        = '0;
                     frame_done_d = 1'b1;
                  end else begin
                     row_d = row_q + ROW_W'(1);
                  end
               end else begin
                  seg_d   = seg_q + SEG_W'(1);
                  state_d = ST_POOL;
               end
            end
         end
         default: state_d = ST_FILL;
      endcase
   end

   // Handshake outputs follow the state; data/last/done come straight from registers.
   always_comb begin
      bus.in_ready   = (state_q != ST_OUT);
      bus.out_valid  = (state_q == ST_OUT);
      bus.out_data   = out_data_q;
      bus.out_last   = out_last_q;
      bus.frame_done = frame_done_q;
   end
endmodule

// File: tb/tb_relu_maxpool_stream.sv
// Directed bench for relu_maxpool_stream: handshake timing, ReLU corners,
// backpressure, full ramp frames and reset during output.
module tb_relu_maxpool_stream;
   localparam int DW    = 16;
   localparam int W     = 28;
   localparam int H     = 28;
   localparam int SEG   = 14;
   localparam int NSEG  = W / SEG;
   localparam int HALF  = SEG / 2;
   localparam int IN_W  = SEG * DW;
   localparam int OUT_W = HALF * DW;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   failures = 0;
   int   fd_count = 0;

   relu_maxpool_stream_if #(.DATA_WIDTH(DW), .SEG(SEG)) bus ();

   relu_maxpool_stream #(.DATA_WIDTH(DW), .W(W), .H(H), .SEG(SEG)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (bus.frame_done) fd_count++;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [IN_W-1:0] fill_seg(input logic [DW-1:0] v);
      logic [IN_W-1:0] d;
      for (int k = 0; k < SEG; k++) d[k*DW +: DW] = v;
      return d;
   endfunction

   function automatic logic [IN_W-1:0] ramp_seg(input int r, input int s);
      logic [IN_W-1:0] d;
      for (int k = 0; k < SEG; k++) d[k*DW +: DW] = 16'(r*W + s*SEG + k);
      return d;
   endfunction

   // Ramp max over a 2x2 window is its bottom-right pixel: row r (odd), column 2j+1.
   function automatic logic [OUT_W-1:0] pool_seg(input int r, input int s);
      logic [OUT_W-1:0] d;
      for (int jj = 0; jj < HALF; jj++) d[jj*DW +: DW] = 16'(r*W + 2*(s*HALF + jj) + 1);
      return d;
   endfunction

   // Drive a segment from a falling edge; returns on the falling edge after acceptance.
   task automatic send(input logic [IN_W-1:0] d);
      int n = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      while (!bus.in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("send_ready_seen", 128'(bus.in_ready), 128'(1));
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_data  = {7{$urandom()}};
      chk("send_fd_low", 128'(bus.frame_done), 128'(0));
   endtask

   task automatic recv(input logic [OUT_W-1:0] exp_d, input logic exp_last);
      int n = 0;
      bus.out_ready = 1'b1;
      while (!bus.out_valid && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("recv_valid_seen", 128'(bus.out_valid), 128'(1));
      chk("recv_data", 128'(bus.out_data), 128'(exp_d));
      chk("recv_last", 128'(bus.out_last), 128'(exp_last));
      @(negedge clk);
      bus.out_ready = 1'b0;
      chk("recv_fd", 128'(bus.frame_done), 128'(exp_last));
      chk("recv_valid_drop", 128'(bus.out_valid), 128'(0));
      if (exp_last) chk("recv_ready_at_fd", 128'(bus.in_ready), 128'(1));
   endtask

   // Ramp frame with random gaps; abort_row >= 0 stops right after that row's first segment is sent.
   task automatic run_frame(input int abort_row);
      for (int r = 0; r < H; r++) begin
         for (int s = 0; s < NSEG; s++) begin
            if (r != 0 || s != 0) repeat ($urandom_range(0, 2)) @(negedge clk);
            send(ramp_seg(r, s));
            if (r == abort_row) return;
            if (r % 2 == 1) begin
               repeat ($urandom_range(0, 3)) @(negedge clk);
               recv(pool_seg(r, s), (r == H-1) && (s == NSEG-1));
            end
         end
      end
   endtask

   logic [IN_W-1:0]  d2, lb3, d3;
   logic [OUT_W-1:0] e2, e3;

   initial begin
      #1000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.in_data   = '0;

      // Power-on reset
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("rst_in_ready", 128'(bus.in_ready), 128'(1));
      chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
      chk("rst_out_data", 128'(bus.out_data), 128'(0));
      chk("rst_out_last", 128'(bus.out_last), 128'(0));
      chk("rst_frame_done", 128'(bus.frame_done), 128'(0));
      chk("rst_row", 128'(dut.row_q), 128'(0));
      chk("rst_seg", 128'(dut.seg_q), 128'(0));

      // Row 0: seg0 all 5, seg1 holds the ReLU corner pixels
      lb3 = fill_seg(16'hFF9C);
      lb3[0*DW +: DW] = 16'hFFF9;
      lb3[1*DW +: DW] = 16'hFFFE;
      lb3[2*DW +: DW] = 16'h8000;
      lb3[3*DW +: DW] = 16'hFFFF;
      lb3[4*DW +: DW] = 16'h7FFF;
      lb3[5*DW +: DW] = 16'h0000;
      send(fill_seg(16'd5));
      send(lb3);

      // Row 1 seg0 = {1,9,-3,-4,0...}: pooled {9,5,5,...}, latency one cycle
      d2 = '0;
      d2[0*DW +: DW] = 16'd1;
      d2[1*DW +: DW] = 16'd9;
      d2[2*DW +: DW] = 16'hFFFD;
      d2[3*DW +: DW] = 16'hFFFC;
      e2 = {7{16'd5}};
      e2[0*DW +: DW] = 16'd9;
      chk("t2_pre_valid", 128'(bus.out_valid), 128'(0));
      send(d2);
      chk("t2_lat1_valid", 128'(bus.out_valid), 128'(1));
      chk("t2_in_stalled", 128'(bus.in_ready), 128'(0));
      @(negedge clk);
      chk("t2_still_stalled", 128'(bus.in_ready), 128'(0));
      recv(e2, 1'b0);

      // Row 1 seg1: windows {-7,-2,-9,-1}->0, {-32768,-1,0,-5}->0, {32767,0,5,5}->32767, rest all negative->0
      d3 = fill_seg(16'hFFCE);
      d3[0*DW +: DW] = 16'hFFF7;
      d3[1*DW +: DW] = 16'hFFFF;
      d3[2*DW +: DW] = 16'h0000;
      d3[3*DW +: DW] = 16'hFFFB;
      d3[4*DW +: DW] = 16'd5;
      d3[5*DW +: DW] = 16'd5;
      e3 = '0;
      e3[2*DW +: DW] = 16'h7FFF;
      send(d3);

      // Backpressure: 10 cycles of out_ready=0 with a competing input offered
      bus.in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         bus.in_data = {7{$urandom()}};
         @(negedge clk);
         chk("t4_hold_data", 128'(bus.out_data), 128'(e3));
         chk("t4_hold_last", 128'(bus.out_last), 128'(0));
         chk("t4_hold_valid", 128'(bus.out_valid), 128'(1));
         chk("t4_no_accept", 128'(bus.in_ready), 128'(0));
      end
      bus.in_valid = 1'b0;
      recv(e3, 1'b0);
      chk("t4_ready_after", 128'(bus.in_ready), 128'(1));
      chk("t4_row2", 128'(dut.row_q), 128'(2));

      // Mid-frame reset asserted between clock edges
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      chk("t1_mid_out_valid", 128'(bus.out_valid), 128'(0));
      chk("t1_mid_frame_done", 128'(bus.frame_done), 128'(0));
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("t1_in_ready", 128'(bus.in_ready), 128'(1));
      chk("t1_row", 128'(dut.row_q), 128'(0));
      chk("t1_seg", 128'(dut.seg_q), 128'(0));

      // Two ramp frames back to back
      run_frame(-1);
      run_frame(-1);

      // Reset while row 13's first pooled segment is on the output
      run_frame(13);
      chk("t6_in_out", 128'(bus.out_valid), 128'(1));
      #2 reset = 1'b1;
      #1;
      chk("t6_valid_drop", 128'(bus.out_valid), 128'(0));
      chk("t6_last_clr", 128'(bus.out_last), 128'(0));
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      run_frame(-1);

      repeat (3) @(negedge clk);
      chk("end_fd_low", 128'(bus.frame_done), 128'(0));
      chk("end_fd_pulses", 128'(fd_count), 128'(3));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
